sram_req_ctrl: RTL and testbench
================================

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 SHALL have parameter RSP_DEPTH, default 2: response FIFO depth; legal values are 2 to 4.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock for all state.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i / req_ready_o, input/output, 1 bit each: request handshake.
REQ-005 SHALL have port req_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port req_addr_i, input, 12 bits: word address.
REQ-007 SHALL have port req_wdata_i, input, 64 bits: write data.
REQ-008 SHALL have port req_be_i, input, 8 bits: byte enables.
REQ-009 SHALL have port rsp_valid_o / rsp_ready_i, output/input, 1 bit each: response handshake.
REQ-010 SHALL have port rsp_rdata_o, output, 64 bits: read data, 0 for write responses.
REQ-011 SHALL have port rsp_err_o, output, 1 bit: parity error on a read.
REQ-012 SHALL have ports sram_ren_o, sram_wen_o, output, 1 bit each; sram_adr_o, output, 12 bits; sram_din_o and sram_wbeb_o, output, 76 bits each; sram_q_i, input, 76 bits.
REQ-013 SHALL drive constant outputs sram_mc_o=3'b000, sram_mcen_o=0, sram_clkbyp_o=0, sram_wa_o=2'b00, sram_wpulse_o=2'b00, sram_wpulseen_o=0, sram_fwen_o=0.

Function
REQ-014 SHALL accept a request on the cycle where req_valid_i and req_ready_o are both 1, and SHALL drive sram_ren_o or sram_wen_o combinationally in that same cycle, never both.
REQ-015 SHALL assert req_ready_o only when (FIFO occupancy + in-flight reads) < RSP_DEPTH, computed without any combinational path from rsp_ready_i.
REQ-016 SHALL map sram_din_o[63:0] to wdata, sram_din_o[71:64] to the parity field (REQ-028), and sram_din_o[75:72] to 0.
REQ-017 SHALL drive sram_wbeb_o active-low: bits [8k+7:8k] = ~be[k]; parity bit 64+k = ~be[k]; bits [75:72] = 1.
REQ-018 SHALL treat sram_wbeb_o as all ones when no write is issued.
REQ-019 SHALL sample sram_q_i exactly one cycle after sram_ren_o and push that sample into the response FIFO in the same cycle.
REQ-020 SHALL push a write response (rdata=0, err=0) one cycle after sram_wen_o.
REQ-021 SHALL deliver responses strictly in request order.
REQ-022 SHALL present rsp_valid_o = FIFO non-empty; it SHALL pop when rsp_valid_o and rsp_ready_i are both 1.
REQ-023 SHALL support push and pop in the same cycle with a full FIFO, leaving occupancy unchanged.
REQ-024 SHALL sustain one request per cycle with one response per cycle when rsp_ready_i is held at 1.
REQ-025 SHALL wrap the FIFO pointers modulo RSP_DEPTH.
REQ-026 SHALL accept req_be_i = 0 as a no-op write that still returns a response.

Reset
REQ-027 SHALL, while rst_i is high, hold req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, sram_ren_o=0, sram_wen_o=0, sram_adr_o=0, sram_din_o=0, sram_wbeb_o=all ones; an in-flight read and all FIFO entries SHALL be discarded; req_ready_o SHALL rise in the first cycle after rst_i deasserts.

Configuration
REQ-028 With SRAM_CTRL_PARITY_EN defined, SHALL write even parity of byte k into bit 64+k and SHALL set rsp_err_o on a read if any enabled-in-storage parity bit mismatches; without the macro, bits [71:64] SHALL be written 0 and rsp_err_o SHALL be constant 0.

Structure
REQ-029 SHALL use package sram_ctrl_pkg for SRAM_AW=12, SRAM_DW=76, DATA_W=64, BE_W=8 and the typedef rsp_t {rdata, err}.
REQ-030 SHALL implement the response buffer as sub-module sram_rsp_fifo, parameterised by depth and element type.

Verification
REQ-031 Write addr 0x005, wdata 0x0123_4567_89AB_CDEF, be 0xFF, then read 0x005 -> rdata 0x0123456789ABCDEF, err 0, read response one cycle after the write response.
REQ-032 Write be 0x0F with wdata all ones to a location holding 0 -> sram_wbeb_o[31:0]=0, [63:32]=1; read-back 0x00000000_FFFFFFFF.
REQ-033 Issue 3 back-to-back reads with rsp_ready_i=0 and RSP_DEPTH=2 -> req_ready_o drops after 2 accepts; releasing rsp_ready_i drains responses in order.
REQ-034 With the macro defined, flip sram_q_i[64] on a read of 0 -> rsp_err_o=1; without the macro -> rsp_err_o=0.
REQ-035 Assert rst_i one cycle after a read is accepted -> no response appears; first post-reset read returns correct data.

Source files
------------

// File: rtl/sram_req_ctrl_pkg.sv
// Shared widths, response record and byte-parity helper for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 12;
  localparam int SRAM_DW = 76;
  localparam int DATA_W  = 64;
  localparam int BE_W    = 8;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  // Even parity per byte: bit k makes byte k plus its parity bit hold an even count of ones.
  function automatic logic [BE_W-1:0] byte_parity(input logic [DATA_W-1:0] d);
    logic [BE_W-1:0] p;
    for (int k = 0; k < BE_W; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request, response and SRAM macro signals of the controller; slave = controller side.
interface sram_req_ctrl_if;
  import sram_ctrl_pkg::*;

  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_we_i;
  logic [SRAM_AW-1:0] req_addr_i;
  logic [DATA_W-1:0]  req_wdata_i;
  logic [BE_W-1:0]    req_be_i;

  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [DATA_W-1:0]  rsp_rdata_o;
  logic               rsp_err_o;

  logic               sram_ren_o;
  logic               sram_wen_o;
  logic [SRAM_AW-1:0] sram_adr_o;
  logic [SRAM_DW-1:0] sram_din_o;
  logic [SRAM_DW-1:0] sram_wbeb_o;
  logic [SRAM_DW-1:0] sram_q_i;
  logic [2:0]         sram_mc_o;
  logic               sram_mcen_o;
  logic               sram_clkbyp_o;
  logic [1:0]         sram_wa_o;
  logic [1:0]         sram_wpulse_o;
  logic               sram_wpulseen_o;
  logic               sram_fwen_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i, sram_q_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output sram_ren_o, sram_wen_o, sram_adr_o, sram_din_o, sram_wbeb_o,
    output sram_mc_o, sram_mcen_o, sram_clkbyp_o, sram_wa_o, sram_wpulse_o,
    output sram_wpulseen_o, sram_fwen_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i, sram_q_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  sram_ren_o, sram_wen_o, sram_adr_o, sram_din_o, sram_wbeb_o,
    input  sram_mc_o, sram_mcen_o, sram_clkbyp_o, sram_wa_o, sram_wpulse_o,
    input  sram_wpulseen_o, sram_fwen_o
  );

endinterface

// File: rtl/sram_req_ctrl_rsp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on pop_vld the same cycle.
// Push and pop may coincide at any occupancy; the producer must never push while full.
module sram_rsp_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_vld,
  input  T              push_dat,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output T              pop_dat,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wr_ptr, rd_ptr;
  T              mem [DEPTH];
  logic          empty, pop_fire, wr_en, rd_adv;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign pop_vld  = !empty || push_vld;
  assign pop_dat  = empty ? push_dat : mem[rd_ptr];
  assign pop_fire = pop_vld && pop_rdy;
  // An entry that bypasses an empty FIFO and is consumed at once never lands in storage.
  assign wr_en    = push_vld && !(empty && pop_fire);
  assign rd_adv   = pop_fire && !empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= next_ptr(wr_ptr);
      if (rd_adv) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_adv);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// SRAM request controller: issues the SRAM access in the accept cycle, response one cycle later, in order.
// req_ready_o is taken from registered occupancy only; SRAM_CTRL_PARITY_EN adds byte parity and read error.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  sram_req_ctrl_if.slave bus
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0]      occ;
  logic [CW:0]        load;
  logic               pend_vld, pend_rd;
  logic               issue, rd_err, fifo_vld;
  logic [BE_W-1:0]    wpar;
  logic [SRAM_DW-1:0] wbeb_dat;
  rsp_t               push_dat, pop_dat;

  // The pending slot is counted so a response always has room when it lands.
  assign load            = {1'b0, occ} + (CW + 1)'(pend_vld);
  assign bus.req_ready_o = !rst_i && (load < (CW + 1)'(RSP_DEPTH));
  assign issue           = bus.req_valid_i && bus.req_ready_o;
  assign bus.sram_ren_o  = issue && !bus.req_we_i;
  assign bus.sram_wen_o  = issue && bus.req_we_i;
  assign bus.sram_adr_o  = issue ? bus.req_addr_i : '0;

`ifdef SRAM_CTRL_PARITY_EN
  logic unused_q;
  assign wpar     = byte_parity(bus.req_wdata_i);
  assign rd_err   = |(bus.sram_q_i[71:64] ^ byte_parity(bus.sram_q_i[63:0]));
  assign unused_q = ^bus.sram_q_i[75:72];
`else
  logic unused_q;
  assign wpar     = '0;
  assign rd_err   = 1'b0;
  assign unused_q = ^bus.sram_q_i[75:64];
`endif

  assign bus.sram_din_o = bus.sram_wen_o ? {4'h0, wpar, bus.req_wdata_i} : '0;

  always_comb begin
    wbeb_dat = '1;
    if (bus.sram_wen_o) begin
      for (int k = 0; k < BE_W; k++) begin
        wbeb_dat[8*k +: 8]    = {8{~bus.req_be_i[k]}};
        wbeb_dat[DATA_W + k]  = ~bus.req_be_i[k];
      end
    end
  end
  assign bus.sram_wbeb_o = wbeb_dat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_vld <= 1'b0;
      pend_rd  <= 1'b0;
    end else begin
      pend_vld <= issue;
      pend_rd  <= bus.sram_ren_o;
    end
  end

  assign push_dat.rdata = pend_rd ? bus.sram_q_i[DATA_W-1:0] : '0;
  assign push_dat.err   = pend_rd && rd_err;

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (pend_vld),
    .push_dat (push_dat),
    .pop_vld  (fifo_vld),
    .pop_rdy  (bus.rsp_ready_i),
    .pop_dat  (pop_dat),
    .count    (occ)
  );

  assign bus.rsp_valid_o = !rst_i && fifo_vld;
  assign bus.rsp_rdata_o = rst_i ? '0 : pop_dat.rdata;
  assign bus.rsp_err_o   = !rst_i && pop_dat.err;

  assign bus.sram_mc_o       = 3'b000;
  assign bus.sram_mcen_o     = 1'b0;
  assign bus.sram_clkbyp_o   = 1'b0;
  assign bus.sram_wa_o       = 2'b00;
  assign bus.sram_wpulse_o   = 2'b00;
  assign bus.sram_wpulseen_o = 1'b0;
  assign bus.sram_fwen_o     = 1'b0;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural 1-cycle-latency SRAM (active-low bit write mask).
module tb_sram_req_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_req_ctrl_if bus ();

  sram_req_ctrl #(.RSP_DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [SRAM_DW-1:0] mem [0:4095];
  logic [SRAM_DW-1:0] q_raw = '0;
  logic               mem_ready = 1'b0;
  logic               flip_par = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem_ready <= 1'b1;
    end else begin
      if (bus.sram_wen_o)
        mem[bus.sram_adr_o] <= (mem[bus.sram_adr_o] & bus.sram_wbeb_o) |
                               (bus.sram_din_o & ~bus.sram_wbeb_o);
      if (bus.sram_ren_o) q_raw <= mem[bus.sram_adr_o];
    end
  end
  assign bus.sram_q_i = q_raw ^ {11'b0, flip_par, 64'b0};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  // Starts and ends just after a rising edge; one request, then waits for its response.
  task automatic do_txn(input logic we, input logic [11:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, output logic [63:0] rdata, output logic err);
    bit got;
    int n;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_be_i    = be;
    bus.rsp_ready_i = 1'b1;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = bus.req_ready_o;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid_i = 1'b0;
    if (!got) timeout("txn_accept");
    got = 0; n = 0; rdata = '0; err = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        got   = 1;
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!got) timeout("txn_response");
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[3];
    logic [11:0] raddr[3];
    logic        rdy2;
    int          acc, acc_hold, cyc;
    logic        par_exp;

    vecs[0]  = '{1'b1, 12'h005, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 12'h005, 64'h0,                   8'h00, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[2]  = '{1'b1, 12'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 12'h010, 64'h0,                   8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[4]  = '{1'b1, 12'h005, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 1'b0};
    vecs[5]  = '{1'b0, 12'h005, 64'h0,                   8'h00, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[6]  = '{1'b1, 12'hFFF, 64'hA5A5_A5A5_A5A5_A5A5, 8'hF0, 64'h0, 1'b0};
    vecs[7]  = '{1'b0, 12'hFFF, 64'h0,                   8'h00, 64'hA5A5_A5A5_0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 12'h020, 64'h0,                   8'h00, 64'h0, 1'b0};
    vecs[9]  = '{1'b1, 12'h010, 64'h0,                   8'h03, 64'h0, 1'b0};
    vecs[10] = '{1'b0, 12'h010, 64'h0,                   8'h00, 64'h0000_0000_FFFF_0000, 1'b0};

    // Reset state, with a request pending to prove the accept is gated.
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 12'h123;
    bus.req_wdata_i = 64'hDEAD_BEEF_0000_1111;
    bus.req_be_i    = 8'hFF;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    check("rst_rsp_err",   bus.rsp_err_o, 0);
    check("rst_sram_ren",  bus.sram_ren_o, 0);
    check("rst_sram_wen",  bus.sram_wen_o, 0);
    check("rst_sram_adr",  bus.sram_adr_o, 0);
    check("rst_sram_din",  bus.sram_din_o, 0);
    check("rst_sram_wbeb", bus.sram_wbeb_o, {76{1'b1}});
    check("const_pins", {bus.sram_mc_o, bus.sram_mcen_o, bus.sram_clkbyp_o, bus.sram_wa_o,
                         bus.sram_wpulse_o, bus.sram_wpulseen_o, bus.sram_fwen_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.req_ready_o, 1);
    check("idle_wbeb", bus.sram_wbeb_o, {76{1'b1}});
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
    end

    // Partial write mask, then a read issued the very next cycle.
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 12'h030;
    bus.req_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF; bus.req_be_i = 8'h0F; bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("seq_wr_ready", bus.req_ready_o, 1);
    check("seq_wr_ren_wen", {bus.sram_ren_o, bus.sram_wen_o}, 2'b01);
    check("seq_wr_adr", bus.sram_adr_o, 12'h030);
    check("seq_wr_wbeb", bus.sram_wbeb_o, 76'hF_F0_FFFFFFFF_00000000);
    check("seq_wr_din", bus.sram_din_o, 76'h0_00_FFFFFFFFFFFFFFFF);
    @(posedge clk); #1;
    bus.req_we_i = 1'b0;
    @(negedge clk);
    check("seq_rd_ren_wen", {bus.sram_ren_o, bus.sram_wen_o}, 2'b10);
    check("seq_rd_wbeb", bus.sram_wbeb_o, {76{1'b1}});
    check("seq_wrsp_valid", bus.rsp_valid_o, 1);
    check("seq_wrsp_rdata", bus.rsp_rdata_o, 0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("seq_rrsp_valid", bus.rsp_valid_o, 1);
    check("seq_rrsp_rdata", bus.rsp_rdata_o, 64'h0000_0000_FFFF_FFFF);
    check("seq_rrsp_err", bus.rsp_err_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("seq_drained", bus.rsp_valid_o, 0);
    @(posedge clk); #1;

    // Three reads against a stalled consumer; accepts must stop at the FIFO depth.
    raddr[0] = 12'h005; raddr[1] = 12'h010; raddr[2] = 12'h020;
    exp_q[0] = 64'h0123_4567_89AB_CDEF;
    exp_q[1] = 64'h0000_0000_FFFF_0000;
    exp_q[2] = 64'h0;
    acc = 0; acc_hold = -1; cyc = 0; rdy2 = 1'b1;
    while (got_q.size() < 3 && cyc < 40) begin
      bus.req_valid_i = (acc < 3);
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = raddr[(acc < 3) ? acc : 0];
      bus.rsp_ready_i = (cyc >= 4);
      @(negedge clk);
      if (cyc == 2) rdy2 = bus.req_ready_o;
      if (bus.req_valid_i && bus.req_ready_o) acc++;
      if (bus.rsp_valid_o && bus.rsp_ready_i) got_q.push_back(bus.rsp_rdata_o);
      if (cyc == 3) acc_hold = acc;
      @(posedge clk); #1;
      cyc++;
    end
    bus.req_valid_i = 1'b0;
    check("bp_ready_cyc2", rdy2, 0);
    check("bp_accepts_stalled", acc_hold, 2);
    if (got_q.size() != 3) timeout("bp_drain");
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check($sformatf("bp_order%0d", i), got_q[i], exp_q[i]);
    end

    // Corrupted parity bit on a read of zero.
`ifdef SRAM_CTRL_PARITY_EN
    par_exp = 1'b1;
`else
    par_exp = 1'b0;
`endif
    flip_par = 1'b1;
    do_txn(1'b0, 12'h020, 64'h0, 8'h00, rd, er);
    flip_par = 1'b0;
    check("par_rdata", rd, 0);
    check("par_err", er, par_exp);

    // Reset lands while a read is in flight.
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 12'h005; bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("rstf_accept", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstf_valid_a", bus.rsp_valid_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstf_valid_b", bus.rsp_valid_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstf_ready", bus.req_ready_o, 1);
    check("rstf_no_stale", bus.rsp_valid_o, 0);
    @(posedge clk); #1;
    do_txn(1'b0, 12'h005, 64'h0, 8'h00, rd, er);
    check("rstf_read_rdata", rd, 64'h0123_4567_89AB_CDEF);
    check("rstf_read_err", er, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
